// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment blink controller.
//   blink_state_e      : blink controller state encoding (IDLE, CONT, BURST)
//   BLANK_CODE_DEFAULT : nibble the downstream decoder renders as all segments off
//   MAX_DIGITS         : widest digit bus the slice helper accepts
//   digit_slice()      : returns digit d (bits 4d+3:4d) of a packed BCD bus
package seven_segment_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONT  = 2'd1,
    BURST = 2'd2
  } blink_state_e;

  localparam logic [3:0]  BLANK_CODE_DEFAULT = 4'hE;
  localparam int unsigned MAX_DIGITS         = 16;

  // Callers zero-extend their bus to 4*MAX_DIGITS bits before calling.
  function automatic logic [3:0] digit_slice(input logic [4*MAX_DIGITS-1:0] bus,
                                             input int unsigned             d);
    logic [4*MAX_DIGITS-1:0] shifted;
    shifted = bus >> (4 * d);
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Blink timebase: counts PRESCALE clocks per half-period and flips the phase
// at each terminal count.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   clear  in  zero the counter and phase this cycle (phase restart / stop)
//   run    in  counter advances while high; held at zero while low
//   phase  out 1 = blanking half-period
//   toggle out one-cycle pulse in the cycle the phase is about to flip
module blink_prescaler
  import seven_segment_pkg::*;
#(
  parameter int unsigned PRESCALE = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic phase,
  output logic toggle
);

  localparam int unsigned      CNT_W = $clog2(PRESCALE) + 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Not gated by clear: the owner decides whether a coincident clear
  // swallows the toggle, which keeps this path free of a loop through clear.
  assign toggle = run && (cnt_q == TERM);
  assign phase  = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear || !run) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == TERM) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/seven_segment_blink_controller.sv
// Blanks selected BCD digits on a self-generated blink timebase, either
// continuously (enable level) or for a fixed number of half-periods (start
// pulse). Sits between the BCD mux and the seven-segment decoder.
//   i_Clk          in  system clock
//   i_Reset_n      in  synchronous active-low reset
//   i_Blink_Enable in  continuous blink while high; overrides any burst
//   i_Blink_Start  in  one-cycle pulse, starts/restarts a burst
//   i_Blink_Mask   in  bit d = 1 blinks digit d
//   i_BCD_Num      in  packed BCD digits
//   o_BCD_Num      out registered digits with blanked ones replaced by BLANK_CODE
//   o_Blink_Phase  out 1 = blanking half-period
//   o_Burst_Busy   out high while in BURST
//   o_Dbg_State    out current state encoding (blink_state_e)
module seven_segment_blink_controller
  import seven_segment_pkg::*;
#(
  parameter int unsigned DECIMAL_DIGITS = 4,
  parameter int unsigned PRESCALE       = 25_000_000,
  parameter int unsigned BURST_TOGGLES  = 6,
  parameter logic [3:0]  BLANK_CODE     = BLANK_CODE_DEFAULT
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset_n,
  input  logic                          i_Blink_Enable,
  input  logic                          i_Blink_Start,
  input  logic [DECIMAL_DIGITS-1:0]     i_Blink_Mask,
  input  logic [4*DECIMAL_DIGITS-1:0]   i_BCD_Num,
  output logic [4*DECIMAL_DIGITS-1:0]   o_BCD_Num,
  output logic                          o_Blink_Phase,
  output logic                          o_Burst_Busy,
  output logic [1:0]                    o_Dbg_State
);

  localparam int unsigned   BW   = $clog2(BURST_TOGGLES + 1);
  localparam logic [BW-1:0] LAST = BW'(BURST_TOGGLES - 1);

  blink_state_e                state_q, state_d;
  logic                        busy_q, busy_d;
  logic [BW-1:0]               burst_cnt_q, burst_cnt_d;
  logic [DECIMAL_DIGITS-1:0]   mask_hist_q, mask_hist_d;
  logic [4*DECIMAL_DIGITS-1:0] bcd_q, bcd_d;

  logic pre_clear, pre_run, pre_phase, pre_toggle;
  logic mask_chg, tick, restart;

  blink_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (i_Clk),
    .rst_n  (i_Reset_n),
    .clear  (pre_clear),
    .run    (pre_run),
    .phase  (pre_phase),
    .toggle (pre_toggle)
  );

  assign pre_run = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    restart     = 1'b0;
    mask_hist_d = i_Blink_Mask;

    // A mask edit restarts the phase so the newly selected digit is shown
    // for a full visible half-period; a toggle coinciding with it is lost.
    mask_chg = (state_q != IDLE) && (i_Blink_Mask != mask_hist_q);
    tick     = pre_toggle && !mask_chg;

    if (i_Blink_Enable) begin
      state_d = CONT;
    end else begin
      case (state_q)
        CONT:    state_d = IDLE;
        IDLE:    if (i_Blink_Start) state_d = BURST;
        BURST: begin
          if (i_Blink_Start) begin
            restart = 1'b1;
          end else if (tick) begin
            if (burst_cnt_q == LAST) state_d = IDLE;
            else                     burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != BURST || restart) burst_cnt_d = '0;

    // Any state change (entry, exit, burst end) and any restart zero the timebase.
    pre_clear = restart || mask_chg || (state_d != state_q) || (state_d == IDLE);
    busy_d    = (state_d == BURST);

    bcd_d = '0;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if ((state_q != IDLE) && pre_phase && i_Blink_Mask[d])
        bcd_d[4*d +: 4] = BLANK_CODE;
      else
        bcd_d[4*d +: 4] = digit_slice((4*MAX_DIGITS)'(i_BCD_Num), d);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
      mask_hist_q <= '0;
      bcd_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
      mask_hist_q <= mask_hist_d;
      bcd_q       <= bcd_d;
    end
  end

  assign o_BCD_Num     = bcd_q;
  assign o_Blink_Phase = pre_phase;
  assign o_Burst_Busy  = busy_q;
  assign o_Dbg_State   = state_q;

endmodule

// File: tb/tb_seven_segment_blink_controller.sv
// Bench for seven_segment_blink_controller: a reference model fills the
// expected queue as each cycle's stimulus is driven; a monitor pops and
// compares after each clock edge. Scenario tasks add their own directed checks.
module tb_seven_segment_blink_controller;

  localparam int P  = 4;
  localparam int BT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        blink_en = 1'b0;
  logic        blink_start = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [15:0] bcd_in = 16'h1234;
  logic [15:0] bcd_out;
  logic        blink_phase, burst_busy;
  logic [1:0]  dbg_state;

  logic        p1_en = 1'b0;
  logic        p1_start = 1'b0;
  logic [3:0]  p1_mask = 4'hF;
  logic [15:0] p1_bcd_in = 16'h1234;
  logic [15:0] p1_bcd_out;
  logic        p1_phase, p1_busy;
  logic [1:0]  p1_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] exp_q[$];

  logic [1:0] m_state = 2'd0;
  int         m_pre   = 0;
  logic       m_phase = 1'b0;
  int         m_cnt   = 0;
  logic [3:0] m_hist  = 4'h0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  seven_segment_blink_controller #(
    .DECIMAL_DIGITS (4),
    .PRESCALE       (P),
    .BURST_TOGGLES  (BT),
    .BLANK_CODE     (4'hE)
  ) u_dut (
    .i_Clk          (clk),
    .i_Reset_n      (rst_n),
    .i_Blink_Enable (blink_en),
    .i_Blink_Start  (blink_start),
    .i_Blink_Mask   (blink_mask),
    .i_BCD_Num      (bcd_in),
    .o_BCD_Num      (bcd_out),
    .o_Blink_Phase  (blink_phase),
    .o_Burst_Busy   (burst_busy),
    .o_Dbg_State    (dbg_state)
  );

  seven_segment_blink_controller #(
    .DECIMAL_DIGITS (4),
    .PRESCALE       (1),
    .BURST_TOGGLES  (BT),
    .BLANK_CODE     (4'hE)
  ) u_dut_p1 (
    .i_Clk          (clk),
    .i_Reset_n      (rst_n),
    .i_Blink_Enable (p1_en),
    .i_Blink_Start  (p1_start),
    .i_Blink_Mask   (p1_mask),
    .i_BCD_Num      (p1_bcd_in),
    .o_BCD_Num      (p1_bcd_out),
    .o_Blink_Phase  (p1_phase),
    .o_Burst_Busy   (p1_busy),
    .o_Dbg_State    (p1_state)
  );

  // ---------------- reference model ----------------
  // Computes what the DUT must show after the coming edge from the inputs
  // now on the pins, and queues it.
  task automatic model_step();
    logic [1:0]  ns;
    int          npre, ncnt;
    logic        nph, wrap, mchg;
    logic [15:0] nout;
    nout = 16'h0;
    if (!rst_n) begin
      ns = 2'd0; npre = 0; nph = 1'b0; ncnt = 0;
    end else begin
      for (int d = 0; d < 4; d++)
        nout[4*d +: 4] = (m_state != 2'd0 && m_phase && blink_mask[d]) ? 4'hE : bcd_in[4*d +: 4];
      wrap = (m_state != 2'd0) && (m_pre == P - 1);
      mchg = (m_state != 2'd0) && (blink_mask != m_hist);
      if (m_state == 2'd0) begin npre = 0; nph = 1'b0; end
      else if (wrap)       begin npre = 0; nph = ~m_phase; end
      else                 begin npre = m_pre + 1; nph = m_phase; end
      ns = m_state; ncnt = m_cnt;
      if (blink_en) begin
        ns = 2'd1; ncnt = 0;
        if (m_state != 2'd1 || mchg) begin npre = 0; nph = 1'b0; end
      end else if (m_state == 2'd1) begin
        ns = 2'd0; npre = 0; nph = 1'b0;
      end else if (m_state == 2'd0) begin
        if (blink_start) begin ns = 2'd2; npre = 0; nph = 1'b0; ncnt = 0; end
      end else begin
        if (blink_start)  begin npre = 0; nph = 1'b0; ncnt = 0; end
        else if (mchg)    begin npre = 0; nph = 1'b0; end
        else if (wrap) begin
          if (m_cnt + 1 == BT) begin ns = 2'd0; ncnt = 0; npre = 0; nph = 1'b0; end
          else ncnt = m_cnt + 1;
        end
      end
    end
    exp_q.push_back({nout, nph, (ns == 2'd2), ns});
    m_state = ns; m_pre = npre; m_phase = nph; m_cnt = ncnt;
    m_hist  = rst_n ? blink_mask : 4'h0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic en, input logic st,
                       input logic [3:0] mask, input logic [15:0] bcd);
    @(negedge clk);
    rst_n       = rst;
    blink_en    = en;
    blink_start = st;
    blink_mask  = mask;
    bcd_in      = bcd;
    model_step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    logic [19:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({bcd_out, blink_phase, burst_busy, dbg_state} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got bcd=%h ph=%b busy=%b st=%0d, expected bcd=%h ph=%b busy=%b st=%0d",
                 $time, bcd_out, blink_phase, burst_busy, dbg_state, e[19:4], e[3], e[2], e[1:0]);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h1234);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h1234);
    @(posedge clk); #1;
    n_tests++;
    if (bcd_out !== 16'h0) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0000", bcd_out); end
    n_tests++;
    if (blink_phase !== 1'b0) begin n_fail++; $display("FAIL reset_phase: got %b expected 0", blink_phase); end
    n_tests++;
    if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", burst_busy); end
  endtask

  task automatic test_cont();
    logic [15:0] exp;
    logic        blank;
    for (int i = 0; i <= 15; i++) begin
      drive(1'b1, (i < 14), 1'b0, 4'b0011, 16'h1234);
      @(posedge clk); #1;
      blank = (i >= 1) && (i <= 14) && ((((i - 1) / 4) % 2) == 1);
      exp   = blank ? 16'h12EE : 16'h1234;
      n_tests++;
      if (bcd_out !== exp) begin
        n_fail++; $display("FAIL cont_out[%0d]: got %h expected %h", i, bcd_out, exp);
      end
    end
  endtask

  task automatic test_burst();
    int          busy_cycles;
    logic [15:0] exp;
    logic        blank;
    busy_cycles = 0;
    for (int i = 0; i <= 20; i++) begin
      drive(1'b1, 1'b0, (i == 0), 4'b1000, 16'h1234);
      @(posedge clk); #1;
      if (burst_busy === 1'b1) busy_cycles++;
      blank = ((i >= 5) && (i <= 8)) || ((i >= 13) && (i <= 16));
      exp   = blank ? 16'hE234 : 16'h1234;
      n_tests++;
      if (bcd_out !== exp) begin
        n_fail++; $display("FAIL burst_out[%0d]: got %h expected %h", i, bcd_out, exp);
      end
      n_tests++;
      if (burst_busy !== (i <= 15)) begin
        n_fail++; $display("FAIL burst_busy[%0d]: got %b expected %b", i, burst_busy, (i <= 15));
      end
    end
    n_tests++;
    if (busy_cycles != 16) begin
      n_fail++; $display("FAIL burst_len: got %0d cycles expected 16", busy_cycles);
    end
  endtask

  task automatic test_burst_restart();
    int   busy_cycles;
    logic dropped;
    busy_cycles = 0;
    dropped     = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      drive(1'b1, 1'b0, (i == 0 || i == 10), 4'b1000, 16'h1234);
      @(posedge clk); #1;
      if (burst_busy === 1'b1) busy_cycles++;
      else                     dropped = 1'b1;
    end
    n_tests++;
    if (!dropped || busy_cycles != 26) begin
      n_fail++; $display("FAIL restart_len: got %0d busy cycles (dropped=%b) expected 26", busy_cycles, dropped);
    end
    // Enable mid-burst takes over; a start while in CONT is ignored.
    for (int i = 0; i <= 24; i++) begin
      drive(1'b1, (i >= 5), (i == 0 || i == 12), 4'b1000, 16'h1234);
      @(posedge clk); #1;
      n_tests++;
      if (burst_busy !== (i < 5) || dbg_state !== ((i < 5) ? 2'd2 : 2'd1)) begin
        n_fail++; $display("FAIL enable_override[%0d]: got busy=%b st=%0d expected busy=%b st=%0d",
                           i, burst_busy, dbg_state, (i < 5), ((i < 5) ? 2 : 1));
      end
    end
    drive(1'b1, 1'b0, 1'b0, 4'b1000, 16'h1234);
  endtask

  task automatic test_mask_change();
    for (int i = 0; i <= 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, (i < 6) ? 4'b0001 : 4'b0100, 16'h1234);
      @(posedge clk); #1;
      if (i == 6) begin
        n_tests++;
        if (blink_phase !== 1'b0) begin n_fail++; $display("FAIL mask_phase: got %b expected 0", blink_phase); end
      end
      if (i >= 7 && i <= 10) begin
        n_tests++;
        if (bcd_out !== 16'h1234) begin n_fail++; $display("FAIL mask_visible[%0d]: got %h expected 1234", i, bcd_out); end
      end
      if (i >= 11) begin
        n_tests++;
        if (bcd_out !== 16'h1E34) begin n_fail++; $display("FAIL mask_blank[%0d]: got %h expected 1e34", i, bcd_out); end
      end
    end
    drive(1'b1, 1'b0, 1'b0, 4'b0100, 16'h1234);
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i <= 5; i++) drive(1'b1, 1'b0, (i == 0), 4'b1111, 16'h5678);
    drive(1'b0, 1'b0, 1'b0, 4'b1111, 16'h5678);
    @(posedge clk); #1;
    n_tests++;
    if ({bcd_out, blink_phase, burst_busy, dbg_state} !== 20'h0) begin
      n_fail++; $display("FAIL midreset: got bcd=%h ph=%b busy=%b st=%0d expected all zero",
                         bcd_out, blink_phase, burst_busy, dbg_state);
    end
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 16'h5678);
    @(posedge clk); #1;
    n_tests++;
    if (bcd_out !== 16'h5678 || burst_busy !== 1'b0) begin
      n_fail++; $display("FAIL after_reset: got bcd=%h busy=%b expected 5678 0", bcd_out, burst_busy);
    end
  endtask

  task automatic test_prescale1();
    logic [15:0] exp;
    @(negedge clk);
    p1_en = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk); #1;
      exp = (i >= 2 && (i % 2) == 0) ? 16'hEEEE : 16'h1234;
      n_tests++;
      if (p1_bcd_out !== exp) begin
        n_fail++; $display("FAIL p1_out[%0d]: got %h expected %h", i, p1_bcd_out, exp);
      end
      n_tests++;
      if (p1_phase !== ((i % 2) == 1)) begin
        n_fail++; $display("FAIL p1_phase[%0d]: got %b expected %b", i, p1_phase, ((i % 2) == 1));
      end
    end
    @(negedge clk);
    p1_en = 1'b0;
  endtask

  task automatic test_random();
    logic        en, st, rst;
    logic [3:0]  m;
    logic [15:0] b;
    en = 1'b0;
    m  = 4'b0101;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 11) == 0) en = ~en;
      st = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) m = 4'($urandom_range(0, 15));
      b   = 16'($urandom_range(0, 65535));
      rst = (i == 299) || ($urandom_range(0, 99) != 0);
      drive(rst, en, st, m, b);
    end
    drive(1'b1, 1'b0, 1'b0, m, 16'h1234);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cont();
    test_burst();
    test_burst_restart();
    test_mask_change();
    test_reset_midburst();
    test_prescale1();
    test_random();
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
